// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared constants and types for the superscalar integer register file.
//   RF_XLEN / RF_NREG / RF_ISSUE are the default data width, architectural
//   register count and issue width; RF_AW is the register address width.
//   REG_ZERO is the hardwired-zero register, REG_A0 the register mirrored on
//   the a0 debug output.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREG  = 32;
    localparam int RF_ISSUE = 2;
    localparam int RF_AW    = $clog2(RF_NREG);

    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

    typedef logic [RF_AW-1:0]   reg_addr_t;
    typedef logic [RF_XLEN-1:0] xlen_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Per-register busy tracking and issue hazard detection.
//   A fired, non-stalled bundle marks the destination of every valid writing
//   way busy; a write-back clears its destination. When both happen to the
//   same register in one cycle the new producer wins, so the bit stays set.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   rs_addr     source addresses, slot 2w = rs1 and 2w+1 = rs2 of way w
//   iss_valid   way holds a valid instruction
//   iss_we      way writes a destination register
//   iss_rd      destination address per way
//   iss_fire    bundle accepted by issue (ignored while stalled)
//   wb_we       write-back enable per way
//   wb_addr     write-back address per way
//   busy        scoreboard, bit r = result for r pending (bit 0 always 0)
//   stall       bundle cannot issue this cycle (0 while in reset)
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int ISSUE = RF_ISSUE,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*ISSUE*AW-1:0] rs_addr,
    input  logic [ISSUE-1:0]      iss_valid,
    input  logic [ISSUE-1:0]      iss_we,
    input  logic [ISSUE*AW-1:0]   iss_rd,
    input  logic                  iss_fire,
    input  logic [ISSUE-1:0]      wb_we,
    input  logic [ISSUE*AW-1:0]   wb_addr,
    output logic [NREG-1:0]       busy,
    output logic                  stall
);

    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [NREG-1:0]  wb_clr;    // registers receiving a write-back this cycle
    logic [NREG-1:0]  busy_set;  // destinations claimed by the issuing bundle
    logic [ISSUE-1:0] way_stall;
    logic [AW-1:0]    src;
    logic [AW-1:0]    rd_w;
    logic [AW-1:0]    rd_v;

    // A pending result that is being written back this cycle is visible
    // through the bypass, so wb_clr also masks RAW and WAW hazards.
    always_comb begin
        wb_clr = '0;
        for (int w = 0; w < ISSUE; w++) begin
            if (wb_we[w]) begin
                wb_clr[wb_addr[w*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every variable written here gets a default before any branch,
        // otherwise the paths that skip an assignment would infer a latch.
        way_stall = '0;
        src       = '0;
        rd_w      = '0;
        rd_v      = '0;
        for (int w = 0; w < ISSUE; w++) begin
            if (iss_valid[w]) begin
                rd_w = iss_rd[w*AW +: AW];
                for (int s = 0; s < 2; s++) begin
                    src = rs_addr[(2*w+s)*AW +: AW];
                    if (src != '0) begin
                        if (busy_q[src] && !wb_clr[src]) begin
                            way_stall[w] = 1'b1;
                        end
                        // Older way in the same bundle produces this source.
                        for (int v = 0; v < w; v++) begin
                            rd_v = iss_rd[v*AW +: AW];
                            if (iss_valid[v] && iss_we[v] && rd_v == src) begin
                                way_stall[w] = 1'b1;
                            end
                        end
                    end
                end
                if (iss_we[w]) begin
                    if (busy_q[rd_w] && !wb_clr[rd_w]) begin
                        way_stall[w] = 1'b1;
                    end
                    if (rd_w != '0) begin
                        for (int v = 0; v < w; v++) begin
                            rd_v = iss_rd[v*AW +: AW];
                            if (iss_valid[v] && iss_we[v] && rd_v == rd_w) begin
                                way_stall[w] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign stall = rst_n & (|way_stall);

    always_comb begin
        busy_set = '0;
        if (iss_fire && !stall) begin
            for (int w = 0; w < ISSUE; w++) begin
                if (iss_valid[w] && iss_we[w] && iss_rd[w*AW +: AW] != '0) begin
                    busy_set[iss_rd[w*AW +: AW]] = 1'b1;
                end
            end
        end
    end

    // Set is applied after clear so a same-cycle new producer keeps the bit.
    assign busy_d = ((busy_q & ~wb_clr) | busy_set) & ~(NREG'(1) << REG_ZERO);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule : rf_scoreboard

// File: rtl/reg_file_ss.sv
// ---------------------------------------------------------------------------
// reg_file_ss
//   Multi-issue integer register file: ISSUE ways, each with two read ports
//   and one write-back port, write-to-read bypass, busy scoreboard and a
//   hazard stall for the issue stage. Register 0 reads as 0 and ignores
//   writes.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   rs_addr     source addresses, slot 2w = rs1 and 2w+1 = rs2 of way w
//   rs_data     read data in slot order, bypassed from same-cycle write-back
//   iss_valid   way holds a valid instruction
//   iss_we      way writes a destination register
//   iss_rd      destination address per way
//   iss_fire    bundle accepted by issue (ignored while stalled)
//   wb_we       write-back enable per way
//   wb_addr     write-back address per way
//   wb_data     write-back data per way
//   stall       bundle cannot issue this cycle
//   busy        scoreboard, bit r = result for r pending
//   a0          registered copy of x10 for debug
// ---------------------------------------------------------------------------
module reg_file_ss
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREG  = RF_NREG,
    parameter int ISSUE = RF_ISSUE,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*ISSUE*AW-1:0]   rs_addr,
    output logic [2*ISSUE*XLEN-1:0] rs_data,
    input  logic [ISSUE-1:0]        iss_valid,
    input  logic [ISSUE-1:0]        iss_we,
    input  logic [ISSUE*AW-1:0]     iss_rd,
    input  logic                    iss_fire,
    input  logic [ISSUE-1:0]        wb_we,
    input  logic [ISSUE*AW-1:0]     wb_addr,
    input  logic [ISSUE*XLEN-1:0]   wb_data,
    output logic                    stall,
    output logic [NREG-1:0]         busy,
    output logic [XLEN-1:0]         a0
);

    localparam int NSLOT = 2 * ISSUE;

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] a0_next;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_val;

    rf_scoreboard #(
        .NREG  (NREG),
        .ISSUE (ISSUE),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rd    (iss_rd),
        .iss_fire  (iss_fire),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .busy      (busy),
        .stall     (stall)
    );

    // Reads: later ways overwrite earlier matches, so the highest-index
    // write-back wins the bypass, matching the storage write priority.
    always_comb begin
        rs_data = '0;
        rd_addr = '0;
        rd_val  = '0;
        if (rst_n) begin
            for (int s = 0; s < NSLOT; s++) begin
                rd_addr = rs_addr[s*AW +: AW];
                rd_val  = '0;
                if (rd_addr != '0) begin
                    rd_val = regs[rd_addr];
                    for (int w = 0; w < ISSUE; w++) begin
                        if (wb_we[w] && wb_addr[w*AW +: AW] == rd_addr) begin
                            rd_val = wb_data[w*XLEN +: XLEN];
                        end
                    end
                end
                rs_data[s*XLEN +: XLEN] = rd_val;
            end
        end
    end

    // NOTE: the whole array is cleared on reset because architectural state
    // must read as zero afterwards; this rules out a plain RAM macro here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            // Last non-blocking write in loop order wins: highest way.
            for (int w = 0; w < ISSUE; w++) begin
                if (wb_we[w] && wb_addr[w*AW +: AW] != '0) begin
                    regs[wb_addr[w*AW +: AW]] <= wb_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // a0 tracks the value x10 will hold after this edge.
    always_comb begin
        a0_next = regs[REG_A0];
        for (int w = 0; w < ISSUE; w++) begin
            if (wb_we[w] && wb_addr[w*AW +: AW] == AW'(REG_A0)) begin
                a0_next = wb_data[w*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0 <= '0;
        end else begin
            a0 <= a0_next;
        end
    end

endmodule : reg_file_ss

// File: tb/tb_reg_file_ss.sv
// ---------------------------------------------------------------------------
// tb_reg_file_ss
//   Scoreboard bench for reg_file_ss. The driver applies one cycle of
//   stimulus after each rising edge, derives the expected outputs from an
//   array-based reference model, and queues them. The monitor pops one entry
//   on every falling edge and compares it with what the DUT presents.
// ---------------------------------------------------------------------------
module tb_reg_file_ss;
    import rf_pkg::*;

    localparam int XLEN  = RF_XLEN;
    localparam int NREG  = RF_NREG;
    localparam int ISSUE = RF_ISSUE;
    localparam int AW    = RF_AW;
    localparam int NSLOT = 2 * ISSUE;

    logic                    clk;
    logic                    rst_n;
    logic [NSLOT*AW-1:0]     rs_addr;
    logic [NSLOT*XLEN-1:0]   rs_data;
    logic [ISSUE-1:0]        iss_valid;
    logic [ISSUE-1:0]        iss_we;
    logic [ISSUE*AW-1:0]     iss_rd;
    logic                    iss_fire;
    logic [ISSUE-1:0]        wb_we;
    logic [ISSUE*AW-1:0]     wb_addr;
    logic [ISSUE*XLEN-1:0]   wb_data;
    logic                    stall;
    logic [NREG-1:0]         busy;
    logic [XLEN-1:0]         a0;

    reg_file_ss #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .ISSUE (ISSUE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rd    (iss_rd),
        .iss_fire  (iss_fire),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall     (stall),
        .busy      (busy),
        .a0        (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NSLOT*XLEN-1:0] rs_data;
        logic                  stall;
        logic [NREG-1:0]       busy;
        logic [XLEN-1:0]       a0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural values and pending-result flags.
    xlen_t m_reg  [NREG];
    bit    m_busy [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rs_addr   = '0;
        iss_valid = '0;
        iss_we    = '0;
        iss_rd    = '0;
        iss_fire  = 1'b0;
        wb_we     = '0;
        wb_addr   = '0;
        wb_data   = '0;
    endtask

    task automatic set_rs(input int s, input int a);
        rs_addr[s*AW +: AW] = AW'(a);
    endtask

    task automatic set_iss(input int w, input int rd);
        iss_valid[w]         = 1'b1;
        iss_we[w]            = 1'b1;
        iss_rd[w*AW +: AW]   = AW'(rd);
    endtask

    task automatic set_wb(input int w, input int a, input logic [XLEN-1:0] d);
        wb_we[w]               = 1'b1;
        wb_addr[w*AW +: AW]    = AW'(a);
        wb_data[w*XLEN +: XLEN] = d;
    endtask

    // ---------------- reference model ----------------
    function automatic void wb_lookup(input int a, output bit hit, output xlen_t d);
        hit = 1'b0;
        d   = '0;
        for (int w = 0; w < ISSUE; w++) begin
            if (wb_we[w] && int'(wb_addr[w*AW +: AW]) == a) begin
                hit = 1'b1;
                d   = wb_data[w*XLEN +: XLEN];
            end
        end
    endfunction

    function automatic xlen_t m_read(input int a);
        bit    hit;
        xlen_t d;
        if (a == REG_ZERO) return '0;
        wb_lookup(a, hit, d);
        return hit ? d : m_reg[a];
    endfunction

    function automatic bit m_pending(input int a);
        bit    hit;
        xlen_t d;
        wb_lookup(a, hit, d);
        return m_busy[a] && !hit;
    endfunction

    function automatic bit m_stall();
        for (int w = 0; w < ISSUE; w++) begin
            int rd = int'(iss_rd[w*AW +: AW]);
            if (!iss_valid[w]) continue;
            for (int s = 0; s < 2; s++) begin
                int src = int'(rs_addr[(2*w+s)*AW +: AW]);
                if (src == REG_ZERO) continue;
                if (m_pending(src)) return 1'b1;
                for (int v = 0; v < w; v++)
                    if (iss_valid[v] && iss_we[v] && int'(iss_rd[v*AW +: AW]) == src) return 1'b1;
            end
            if (iss_we[w]) begin
                if (m_pending(rd)) return 1'b1;
                if (rd != REG_ZERO)
                    for (int v = 0; v < w; v++)
                        if (iss_valid[v] && iss_we[v] && int'(iss_rd[v*AW +: AW]) == rd) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic m_commit(input bit st);
        for (int w = 0; w < ISSUE; w++) begin
            int a = int'(wb_addr[w*AW +: AW]);
            if (wb_we[w]) begin
                if (a != REG_ZERO) m_reg[a] = wb_data[w*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (iss_fire && !st)
            for (int w = 0; w < ISSUE; w++)
                if (iss_valid[w] && iss_we[w] && iss_rd[w*AW +: AW] != '0)
                    m_busy[int'(iss_rd[w*AW +: AW])] = 1'b1;
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic cycle();
        exp_t e;
        bit   st;
        st = m_stall();
        e.rs_data = '0;
        e.stall   = 1'b0;
        e.busy    = '0;
        e.a0      = '0;
        if (rst_n) begin
            for (int s = 0; s < NSLOT; s++)
                e.rs_data[s*XLEN +: XLEN] = m_read(int'(rs_addr[s*AW +: AW]));
            e.stall = st;
            for (int r = 0; r < NREG; r++) e.busy[r] = m_busy[r];
            e.a0 = m_reg[REG_A0];
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_n) m_commit(st);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int s = 0; s < NSLOT; s++)
                check($sformatf("rs_data[%0d]", s), 64'(rs_data[s*XLEN +: XLEN]),
                      64'(mon_e.rs_data[s*XLEN +: XLEN]));
            check("stall", 64'(stall), 64'(mon_e.stall));
            check("busy", 64'(busy), 64'(mon_e.busy));
            check("a0", 64'(a0), 64'(mon_e.a0));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cand[$];
        int guard;
        rst_n = 1'b0;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        cycle();
        rst_n = 1'b1;

        // Reset mid-run with x5 = 0xDEAD and busy[5] set.
        idle(); set_wb(0, 5, 32'hDEAD);                     cycle();
        idle(); set_iss(0, 5); iss_fire = 1'b1; set_rs(0, 5); cycle();
        idle(); set_rs(0, 5); set_rs(1, 5);                 cycle();
        idle(); set_rs(0, 5); set_wb(1, 5, 32'h5555); set_iss(1, 5);
        rst_n = 1'b0;
        m_reset();
        cycle();
        idle(); set_rs(0, 5);                               cycle();
        rst_n = 1'b1;
        idle(); set_rs(0, 5); set_rs(2, 10);                cycle();
        // In-flight write-back after reset.
        idle(); set_wb(1, 5, 32'hBEEF);                     cycle();
        idle(); set_rs(3, 5);                               cycle();

        // Bypass of x10, then a0 follows.
        idle(); set_wb(0, 10, 32'h1234); set_rs(0, 10);     cycle();
        idle(); set_rs(0, 10);                              cycle();

        // Same-address write-back conflict: highest way wins.
        idle(); set_wb(0, 7, 32'h1); set_wb(1, 7, 32'h2); set_rs(1, 7); cycle();
        idle(); set_rs(2, 7);                               cycle();

        // x0: writes dropped, never busy, never stalls.
        idle(); set_wb(0, 0, 32'hFFFF_FFFF); set_iss(0, 0); set_rs(0, 0); set_rs(1, 0);
        iss_fire = 1'b1;                                     cycle();
        idle(); set_rs(0, 0); set_rs(3, 0);                 cycle();

        // RAW / WAW against the scoreboard.
        idle(); set_iss(0, 3); iss_fire = 1'b1;             cycle();
        idle(); set_iss(0, 8); set_rs(0, 3); iss_fire = 1'b1; cycle();
        idle(); set_iss(0, 8); set_rs(0, 3); iss_fire = 1'b1; cycle();
        idle(); set_iss(1, 3); iss_fire = 1'b1;             cycle();
        idle(); set_iss(0, 8); set_rs(0, 3); iss_fire = 1'b1;
        set_wb(0, 3, 32'hABCD);                             cycle();
        idle(); set_rs(1, 3); set_rs(2, 8);                 cycle();
        // Intra-bundle RAW and WAW.
        idle(); set_iss(0, 9); set_rs(2, 9); iss_valid[1] = 1'b1; iss_fire = 1'b1; cycle();
        idle(); set_iss(0, 11); set_iss(1, 11); iss_fire = 1'b1; cycle();
        idle(); set_iss(0, 12); iss_valid[1] = 1'b0; set_rs(2, 12); iss_fire = 1'b1; cycle();

        // Same-cycle clear and set of x4: set wins.
        idle(); set_iss(0, 4); iss_fire = 1'b1;             cycle();
        idle(); set_wb(1, 4, 32'h44); set_iss(1, 4); iss_fire = 1'b1; cycle();
        idle(); set_rs(0, 4);                               cycle();

        // Randomised traffic over a narrow register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int s = 0; s < NSLOT; s++) set_rs(s, $urandom_range(0, 15));
            for (int w = 0; w < ISSUE; w++) begin
                iss_valid[w]       = 1'($urandom_range(0, 1));
                iss_we[w]          = 1'($urandom_range(0, 1));
                iss_rd[w*AW +: AW] = AW'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    cand.delete();
                    for (int r = 1; r < NREG; r++) if (m_busy[r]) cand.push_back(r);
                    if (cand.size() > 0 && $urandom_range(0, 2) != 0)
                        set_wb(w, cand[$urandom_range(0, cand.size() - 1)], $urandom());
                    else
                        set_wb(w, $urandom_range(0, 15), $urandom());
                end
            end
            iss_fire = ($urandom_range(0, 3) != 0);
            if (i == 200) begin
                rst_n = 1'b0;
                m_reset();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        idle();
        repeat (3) cycle();

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_reg_file_ss
